rcs_divider_ctrl: RTL

//  Sequencer that runs 4-bit unsigned restoring division on the shared four_bit_RCS

---
 rtl/rcs_divider_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rcs_divider_ctrl.sv
// rcs_divider_ctrl: restoring 4-bit unsigned divider sequencer.
// Uses an external ripple-carry subtractor (sub_a - sub_b, sub_cout=1 means no borrow)
// and produces one quotient bit per RUN cycle. Operands arrive and results leave on
// valid/ready handshakes. A result is held under back-pressure.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, outputs read zero
// RUN   | four shift/subtract iterations, one quotient bit per cycle
// DONE  | result presented on out_valid until the consumer takes it
module rcs_divider_ctrl #(
    parameter bit         DZ_FAST = 1'b1,
    parameter logic [3:0] DZ_QUOT = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] sub_a,
    output logic [3:0] sub_b,
    input  logic [3:0] sub_s,
    input  logic       sub_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] r_q, r_nxt;
    logic [3:0] q_q, q_nxt;
    logic [3:0] d_q, d_nxt;
    logic [1:0] cnt_q, cnt_nxt;
    logic       dz_q, dz_nxt;

    logic       accept;
    logic       take;
    logic       msb;
    logic       dz_in;
    logic [3:0] rs;

    // State and datapath registers, synchronously cleared so an in-flight op is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            r_q   <= 4'd0;
            q_q   <= 4'd0;
            d_q   <= 4'd0;
            cnt_q <= 2'd0;
            dz_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            r_q   <= r_nxt;
            q_q   <= q_nxt;
            d_q   <= d_nxt;
            cnt_q <= cnt_nxt;
            dz_q  <= dz_nxt;
        end
    end

    // Next-state, iteration datapath and handshake decode.
    always_comb begin
        state_nxt = state;
        r_nxt     = r_q;
        q_nxt     = q_q;
        d_nxt     = d_q;
        cnt_nxt   = cnt_q;
        dz_nxt    = dz_q;

        in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        accept    = in_valid && in_ready;
        dz_in     = (divisor == 4'd0);

        rs        = {r_q[2:0], q_q[3]};
        msb       = r_q[3];
        // A set msb means the shifted remainder overflowed 4 bits, so it is surely >= D.
        take      = msb || sub_cout;

        sub_a     = 4'd0;
        sub_b     = d_q;

        case (state)
            ST_IDLE: begin
            end
            ST_RUN: begin
                sub_a   = rs;
                r_nxt   = take ? sub_s : rs;
                q_nxt   = {q_q[2:0], take};
                cnt_nxt = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A new accept overrides the DONE->IDLE return so results can stream back-to-back.
        if (accept) begin
            q_nxt   = dividend;
            d_nxt   = divisor;
            cnt_nxt = 2'd0;
            dz_nxt  = dz_in;
            if (dz_in && DZ_FAST) begin
                r_nxt     = dividend;
                state_nxt = ST_DONE;
            end else begin
                r_nxt     = 4'd0;
                state_nxt = ST_RUN;
            end
        end
    end

    // Result outputs come straight from registers and read zero outside DONE.
    always_comb begin
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        quotient  = 4'd0;
        remainder = 4'd0;
        div_zero  = 1'b0;
        if (state == ST_DONE) begin
            quotient  = dz_q ? DZ_QUOT : q_q;
            remainder = r_q;
            div_zero  = dz_q;
        end
    end

endmodule
